// File: rtl/ksa_seq_ctrl.sv
// rtl/ksa_seq_ctrl.sv - sequential slice-wise carry-propagate adder (optional subtract via KSA_SEQ_SUB_EN)
// One N-bit slice is added per cycle, LSB first; the result is held until the consumer takes it.
module ksa_seq_ctrl #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 c_in,
`ifdef KSA_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS:0]     sum,
    output logic                 busy
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_r, b_r, res_r;
    logic          carry_r;
    logic [IW-1:0] idx_r;
    logic [N:0]    slice;
    logic [W-1:0]  b_eff;
    logic          c_eff;
    logic          last_slice;

    assign last_slice = (idx_r == LAST_IDX);

`ifdef KSA_SEQ_SUB_EN
    // Two's-complement subtract: invert B and seed the carry chain with 1.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : c_in;
`else
    assign b_eff = b;
    assign c_eff = c_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    always_comb begin
        slice = {1'b0, a_r[N*int'(idx_r) +: N]} + {1'b0, b_r[N*int'(idx_r) +: N]}
              + {{N{1'b0}}, carry_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b_eff;
                        carry_r <= c_eff;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    res_r[N*int'(idx_r) +: N] <= slice[N-1:0];
                    carry_r                   <= slice[N];
                    if (!last_slice) idx_r <= idx_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum = {carry_r, res_r};

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// tb/tb_ksa_seq_ctrl.sv - scoreboard bench for ksa_seq_ctrl (N=4, WORDS=4)
module tb_ksa_seq_ctrl;

    localparam int N = 4;
    localparam int WORDS = 4;
    localparam int W = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         sub_v = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W:0]   sum;
    logic         busy;

    int checks = 0;
    int passes = 0;
    int mode = 0;
    logic [W:0] exp_q[$];

    ksa_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
`ifdef KSA_SEQ_SUB_EN
        .sub(sub_v),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
    );

    always #5 clk = ~clk;

    // mode 0: always ready, 1: random stalls, 2: held low
    always @(posedge clk) begin
        #1;
        if (mode == 0)      out_ready = 1'b1;
        else if (mode == 2) out_ready = 1'b0;
        else                out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        logic [W-1:0] nb;
        nb = ~mb;
`ifdef KSA_SEQ_SUB_EN
        if (ms) return {1'b0, ma} + {1'b0, nb} + (W+1)'(1);
`else
        if (ms && nb == '0) return '0;
`endif
        return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    endfunction

    // Monitor: every cycle with a valid result is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", sum, '1);
            end else if (out_ready) begin
                chk("sum", sum, exp_q.pop_front());
            end else begin
                chk("sum_hold", sum, exp_q[0]);
            end
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic is, input bit push);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", {{W{1'b0}}, in_ready}, 1);
        in_valid = 1'b1;
        a = ia; b = ib; c_in = ic; sub_v = is;
        if (push) exp_q.push_back(model(ia, ib, ic, is));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub_v = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (W+1)'(exp_q.size()), 0);
    endtask

    initial begin
        logic sub_sel;
        int t;
        sub_sel = 1'b0;

        @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_in_ready", {{W{1'b0}}, in_ready}, 1);
        chk("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
        chk("rst_busy", {{W{1'b0}}, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: out_valid only after the fourth edge following accept.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("latency_ov%0d", k), {{W{1'b0}}, out_valid}, (k == 4) ? 1 : 0);
            if (k < 4) chk($sformatf("latency_busy%0d", k), {{W{1'b0}}, busy}, 1);
        end
        drain();

        // Requests presented during RUN must be ignored.
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1);
        @(negedge clk);
        chk("run_in_ready", {{W{1'b0}}, in_ready}, 0);
        in_valid = 1'b1; a = 16'h0005; b = 16'h0005;
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Output held across a consumer stall.
        mode = 2;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_sum", sum, 17'h05555);
            chk("stall_ov", {{W{1'b0}}, out_valid}, 1);
        end
        mode = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", {{W{1'b0}}, in_ready}, 1);
        chk("release_ov", {{W{1'b0}}, out_valid}, 0);

        // Reset abort mid-operation, then a clean request.
        issue(16'hABCD, 16'h7777, 1'b1, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ov", {{W{1'b0}}, out_valid}, 0);
        chk("abort_in_ready", {{W{1'b0}}, in_ready}, 1);
        chk("abort_sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 1);
        drain();
        chk("post_abort_expect", model(16'h0003, 16'h0004, 1'b0, 1'b0), 17'h00007);

`ifdef KSA_SEQ_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1);
        drain();
        sub_sel = 1'b1;
`endif

        mode = 1;
        for (int i = 0; i < 3000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), sub_sel & 1'($urandom), 1);
        end
        drain();
        mode = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
